apb_i2c_reg_bank: RTL
=====================

// Module: apb_i2c_reg_bank
// PURPOSE
//  Next-generation APB slave register bank for the I2C controller: decodes APB accesses into the I2C register map
//  (transmit, receive, slave address, command, status, prescale, interrupt). Adds what the first-generation
//  interface lacks: programmable wait states, PSLVERR, TX/RX FIFO push/pop strobes, a self-clearing START bit,
//  and a maskable, sticky interrupt. Sits between the APB bus and the I2C core/FIFOs.
// PARAMETERS
//  ADDR_WIDTH    8      APB address width
//  DATA_WIDTH    8      APB data width (>=8); registers use bits [7:0], upper read bits are 0, upper write bits ignored
//  BASE_ADDR     8'hC0  base of register window; offsets 0..7 decoded, paddr_i[ADDR_WIDTH-1:3] must equal BASE_ADDR>>3
//  WAIT_STATES   0      ACCESS cycles with pready_o=0 before completion (0..15)
//  PRESCALE_RST  8'h00  reset value of PRESCALE
// PORTS
//  pclk_i             in   1           clock
//  preset_ni          in   1           asynchronous reset, active low
//  paddr_i            in   ADDR_WIDTH  APB address
//  pwrite_i           in   1           1 write, 0 read
//  psel_i             in   1           slave select
//  penable_i          in   1           APB access phase
//  pwdata_i           in   DATA_WIDTH  write data
//  prdata_o           out  DATA_WIDTH  read data, valid only while pready_o=1
//  pready_o           out  1           transfer completes this cycle
//  pslverr_o          out  1           error response, valid only while pready_o=1
//  status_i           in   8           live I2C core status
//  rx_data_i          in   8           RX FIFO head data
//  rx_empty_i         in   1           RX FIFO empty
//  tx_full_i          in   1           TX FIFO full
//  tx_push_o          out  1           1-cycle TX FIFO write strobe
//  tx_data_o          out  8           TX FIFO write data (valid with tx_push_o)
//  rx_pop_o           out  1           1-cycle RX FIFO read strobe
//  slave_addr_o       out  8           SLAVE_ADDR register
//  command_o          out  8           COMMAND register (bit0 = START)
//  prescale_o         out  8           PRESCALE register
//  cmd_start_o        out  1           1-cycle pulse when START is written 1
//  irq_o              out  1           |(INT_STATUS & INT_ENABLE), registered
// BEHAVIOUR
//  Map (offset): 0 TX (W) push; 1 RX (R) pop; 2 SLAVE_ADDR RW; 3 COMMAND RW; 4 STATUS R (=status_i);
//   5 PRESCALE RW; 6 INT_ENABLE RW; 7 INT_STATUS R/W1C. Write to R reg / read of TX -> pslverr, no effect.
//  FSM: IDLE -(psel & !penable)-> SETUP -> ACCESS. In ACCESS, wait counter loaded with WAIT_STATES on SETUP
//   decrements each cycle; pready_o = ACCESS & psel & penable & (cnt==0). Completion cycle = pready_o high.
//   After completion: SETUP if psel & !penable, else IDLE. psel_i low in ACCESS -> IDLE, no commit.
//  WAIT_STATES=0: pready_o high in first ACCESS cycle (classic 2-cycle APB). N: completes in ACCESS cycle N+1.
//  Commit happens exactly once, on the completion cycle only; all side-effects register at that clock edge.
//  pslverr_o=1 on completion if: address outside window; TX write while tx_full_i; RX read while rx_empty_i;
//   wrong direction. Errored accesses have no side effect; error read returns prdata_o=0.
//  TX write ok: tx_push_o=1 and tx_data_o=pwdata_i[7:0] for the cycle after completion edge (one cycle).
//  RX read ok: prdata_o=rx_data_i on completion cycle; rx_pop_o=1 the following cycle (one cycle).
//  COMMAND write with bit0=1: cmd_start_o pulses 1 cycle after; command_o[0] clears one cycle after the pulse;
//   other bits hold as written.
//  INT_STATUS[i] sets on rising edge of status_i[i] (status_i sampled each cycle into a delay reg).
//   W1C clears bits written 1; set and clear in same cycle -> set wins.
//  irq_o updated one cycle after INT_STATUS/INT_ENABLE change.
//  prdata_o, pslverr_o = 0 whenever pready_o=0.
//  Reset (async, preset_ni=0): FSM IDLE, counter 0, all registers 0 except PRESCALE=PRESCALE_RST;
//   pready_o, pslverr_o, prdata_o, strobes, cmd_start_o, irq_o = 0. Reset mid-transfer aborts, no commit.
// TESTING
//  1 WAIT_STATES=0: write 0x93 to 0xC2, read 0xC2 -> pready high 2nd cycle, prdata_o=0x93, pslverr_o=0.
//  2 WAIT_STATES=3: write 0x10 to 0xC5 -> pready_o low 3 ACCESS cycles, high 4th; prescale_o=0x10 after.
//  3 Write 0xAA to 0xC0, tx_full_i=0 -> one tx_push_o, tx_data_o=0xAA; repeat with tx_full_i=1 -> pslverr, no push.
//  4 Read 0xC1, rx_data_i=0xF1, rx_empty_i=0 -> prdata_o=0xF1, one rx_pop_o; rx_empty_i=1 -> pslverr, prdata 0, no pop.
//  5 INT_ENABLE=0x01, status_i[0] 0->1 -> INT_STATUS=0x01, irq_o=1; W1C 0x01 to 0xC7 -> irq_o=0; same-cycle edge keeps 1.
//  6 Write 0x01 to 0xC3 -> single cmd_start_o pulse, command_o[0] self-clears; preset_ni low mid-ACCESS -> no commit.

Source files
------------

// File: rtl/apb_i2c_reg_bank.sv
// APB slave register bank for the I2C controller: TX/RX FIFO strobes, config registers,
// programmable wait states, PSLVERR and a maskable sticky interrupt.
module apb_i2c_reg_bank #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 8'hC0,
    parameter int                    WAIT_STATES  = 0,
    parameter logic [7:0]            PRESCALE_RST = 8'h00
) (
    input  logic                  pclk_i,
    input  logic                  preset_ni,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic                  pwrite_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    input  logic [7:0]            status_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_empty_i,
    input  logic                  tx_full_i,
    output logic                  tx_push_o,
    output logic [7:0]            tx_data_o,
    output logic                  rx_pop_o,
    output logic [7:0]            slave_addr_o,
    output logic [7:0]            command_o,
    output logic [7:0]            prescale_o,
    output logic                  cmd_start_o,
    output logic                  irq_o
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

    state_e     state_q, state_d, phase;
    logic [3:0] cnt_q, cnt_d;
    logic       tx_push_q, tx_push_d, rx_pop_q, rx_pop_d, cmd_start_q, cmd_start_d, irq_q, irq_d;
    logic [7:0] tx_data_q, tx_data_d, slave_addr_q, slave_addr_d, command_q, command_d;
    logic [7:0] prescale_q, prescale_d, int_en_q, int_en_d, int_status_q, int_status_d;
    logic [7:0] status_dly_q, w1c, rd8;
    logic [2:0] offset;
    logic       in_win, err, ready, wr_ok, rd_ok;

    // SETUP is the bus setup cycle itself, so a zero-wait access completes on the next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase   = state_q;
        if (state_q == IDLE && psel_i && !penable_i) phase = SETUP;
        ready = (state_q == ACCESS) && psel_i && penable_i && (cnt_q == 4'd0);
        case (phase)
            IDLE:  state_d = IDLE;
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = WAIT_LD;
            end
            ACCESS: begin
                if (!psel_i || ready) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        offset = paddr_i[2:0];
        in_win = (paddr_i[ADDR_WIDTH-1:3] == BASE_ADDR[ADDR_WIDTH-1:3]);
        err    = 1'b0;
        rd8    = 8'h00;
        if (!in_win) begin
            err = 1'b1;
        end else begin
            case (offset)
                3'd0: err = !pwrite_i || tx_full_i;
                3'd1: begin
                    err = pwrite_i || rx_empty_i;
                    rd8 = rx_data_i;
                end
                3'd2: rd8 = slave_addr_q;
                3'd3: rd8 = command_q;
                3'd4: begin
                    err = pwrite_i;
                    rd8 = status_i;
                end
                3'd5: rd8 = prescale_q;
                3'd6: rd8 = int_en_q;
                default: rd8 = int_status_q;
            endcase
        end
        prdata_o  = '0;
        pslverr_o = 1'b0;
        pready_o  = ready;
        if (ready) begin
            pslverr_o = err;
            if (!err && !pwrite_i) prdata_o[7:0] = rd8;
        end
        wr_ok = ready && !err && pwrite_i;
        rd_ok = ready && !err && !pwrite_i;
    end

    // Side effects only on the completion cycle of an error-free access.
    always_comb begin
        tx_push_d    = wr_ok && (offset == 3'd0);
        tx_data_d    = tx_push_d ? pwdata_i[7:0] : tx_data_q;
        rx_pop_d     = rd_ok && (offset == 3'd1);
        slave_addr_d = (wr_ok && offset == 3'd2) ? pwdata_i[7:0] : slave_addr_q;
        prescale_d   = (wr_ok && offset == 3'd5) ? pwdata_i[7:0] : prescale_q;
        int_en_d     = (wr_ok && offset == 3'd6) ? pwdata_i[7:0] : int_en_q;
        cmd_start_d  = wr_ok && (offset == 3'd3) && pwdata_i[0];
        command_d    = command_q;
        if (cmd_start_q) command_d[0] = 1'b0;
        if (wr_ok && offset == 3'd3) command_d = pwdata_i[7:0];
        w1c          = (wr_ok && offset == 3'd7) ? pwdata_i[7:0] : 8'h00;
        int_status_d = (int_status_q & ~w1c) | (status_i & ~status_dly_q);
        irq_d        = |(int_status_q & int_en_q);
    end

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            tx_push_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            rx_pop_q     <= 1'b0;
            slave_addr_q <= 8'h00;
            command_q    <= 8'h00;
            cmd_start_q  <= 1'b0;
            prescale_q   <= PRESCALE_RST;
            int_en_q     <= 8'h00;
            int_status_q <= 8'h00;
            status_dly_q <= 8'h00;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_push_q    <= tx_push_d;
            tx_data_q    <= tx_data_d;
            rx_pop_q     <= rx_pop_d;
            slave_addr_q <= slave_addr_d;
            command_q    <= command_d;
            cmd_start_q  <= cmd_start_d;
            prescale_q   <= prescale_d;
            int_en_q     <= int_en_d;
            int_status_q <= int_status_d;
            status_dly_q <= status_i;
            irq_q        <= irq_d;
        end
    end

    assign tx_push_o    = tx_push_q;
    assign tx_data_o    = tx_data_q;
    assign rx_pop_o     = rx_pop_q;
    assign slave_addr_o = slave_addr_q;
    assign command_o    = command_q;
    assign prescale_o   = prescale_q;
    assign cmd_start_o  = cmd_start_q;
    assign irq_o        = irq_q;

endmodule
